decode_stage: RTL and testbench

- RV32I decode/operand stage directly upstream of the combinational ALU.
- Decodes one instruction per handshake and reads the register file through external combinational read ports, with a write-back bypass.
- Registers alu_ctrl, data_x, data_y plus sideband into a single-entry ID/EX pipeline register, with valid/ready flow control and flush.

---
 rtl/rv32_pkg.sv | 60 ++++++
 rtl/imm_gen.sv | 20 ++
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// RV32I encoding constants shared by the decode stage and the ALU.
package rv32_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ImmI,
        ImmS,
        ImmU
    } imm_fmt_e;

    // alt selects SUB/SRA; callers decide whether alt is legal for the funct3.
    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            F3_AND:     return ALU_AND;
            default:    return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended I/S/U immediate extraction; only instruction bits [31:7] carry immediates.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmU:    imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/operand stage: decodes, reads operands with write-back bypass and
// registers the ALU command into a single-entry ID/EX register with valid/ready.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] data_x,
    output logic [XLEN-1:0] data_y,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic [XLEN-1:0] ex_store_data,
    output logic [2:0]      ex_funct3,
    output logic [31:0]     ex_pc,
    output logic            ex_unsup,
    output logic [31:0]     stall_cnt
);

    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            we,
        input logic [4:0]      rd,
        input logic [XLEN-1:0] wdata
    );
        if (addr == 5'd0) return '0;
        if (we && rd == addr) return wdata;
        return rf_data;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            alt;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [31:0]     imm;
    imm_fmt_e        imm_fmt;
    logic            accept;

    logic [3:0]      d_alu;
    logic [XLEN-1:0] d_x;
    logic [XLEN-1:0] d_y;
    logic            d_rd_we;
    logic            d_mem_rd;
    logic            d_mem_wr;
    logic            d_unsup;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign alt      = (funct7 == F7_ALT);
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign rs1_val = read_operand(rs1_addr, rs1_data, wb_we, wb_rd, wb_data);
    assign rs2_val = read_operand(rs2_addr, rs2_data, wb_we, wb_rd, wb_data);

    assign in_ready = !ex_valid || ex_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        imm_fmt = ImmI;
        case (opcode)
            OPC_STORE:          imm_fmt = ImmS;
            OPC_LUI, OPC_AUIPC: imm_fmt = ImmU;
            default:            imm_fmt = ImmI;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    always_comb begin
        d_alu    = ALU_ADD;
        d_x      = '0;
        d_y      = '0;
        d_rd_we  = 1'b0;
        d_mem_rd = 1'b0;
        d_mem_wr = 1'b0;
        d_unsup  = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            d_unsup = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    d_x     = rs1_val;
                    d_y     = rs2_val;
                    d_rd_we = 1'b1;
                    if (funct7 == F7_BASE ||
                        (alt && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
                        d_alu = alu_op(funct3, alt);
                    end else begin
                        d_unsup = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    d_x     = rs1_val;
                    d_y     = imm;
                    d_rd_we = 1'b1;
                    if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                        // The ALU shifts by the whole operand, so only shamt may reach it.
                        d_y = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        if (funct7 == F7_BASE || (alt && funct3 == F3_SRL_SRA)) begin
                            d_alu = alu_op(funct3, alt);
                        end else begin
                            d_unsup = 1'b1;
                        end
                    end else begin
                        d_alu = alu_op(funct3, 1'b0);
                    end
                end
                OPC_LUI: begin
                    d_y     = imm;
                    d_rd_we = 1'b1;
                end
                OPC_AUIPC: begin
                    d_x     = in_pc;
                    d_y     = imm;
                    d_rd_we = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    d_x     = in_pc;
                    d_y     = XLEN'(4);
                    d_rd_we = 1'b1;
                end
                OPC_LOAD: begin
                    d_x      = rs1_val;
                    d_y      = imm;
                    d_rd_we  = 1'b1;
                    d_mem_rd = 1'b1;
                end
                OPC_STORE: begin
                    d_x      = rs1_val;
                    d_y      = imm;
                    d_mem_wr = 1'b1;
                end
                OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: d_unsup = 1'b1;
                default:                               d_unsup = 1'b1;
            endcase
        end
        if (d_unsup) begin
            d_alu    = ALU_ADD;
            d_x      = '0;
            d_y      = '0;
            d_rd_we  = 1'b0;
            d_mem_rd = 1'b0;
            d_mem_wr = 1'b0;
        end
        if (rd == 5'd0) d_rd_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            alu_ctrl      <= ALU_ADD;
            data_x        <= '0;
            data_y        <= '0;
            ex_rd         <= '0;
            ex_rd_we      <= 1'b0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            ex_store_data <= '0;
            ex_funct3     <= '0;
            ex_pc         <= RESET_PC;
            ex_unsup      <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid      <= 1'b1;
            alu_ctrl      <= d_alu;
            data_x        <= d_x;
            data_y        <= d_y;
            ex_rd         <= rd;
            ex_rd_we      <= d_rd_we;
            ex_mem_rd     <= d_mem_rd;
            ex_mem_wr     <= d_mem_wr;
            ex_store_data <= rs2_val;
            ex_funct3     <= funct3;
            ex_pc         <= in_pc;
            ex_unsup      <= d_unsup;
        end else if (in_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (ex_valid && !ex_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then randomized traffic against a reference model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, wb_we, ex_valid, ex_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data, wb_data;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd, ex_rd;
    logic [3:0]  alu_ctrl;
    logic [31:0] data_x, data_y, ex_store_data, ex_pc, stall_cnt;
    logic        ex_rd_we, ex_mem_rd, ex_mem_wr, ex_unsup;
    logic [2:0]  ex_funct3;

    logic [31:0] rf [32];
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_ctrl      (alu_ctrl),
        .data_x        (data_x),
        .data_y        (data_y),
        .ex_rd         (ex_rd),
        .ex_rd_we      (ex_rd_we),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_unsup      (ex_unsup),
        .stall_cnt     (stall_cnt)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic        unsup;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_valid;
    exp_t        m;
    logic [31:0] m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] a, input logic we,
                                            input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        return (we && wrd == a) ? wd : rf[a];
    endfunction

    // Architectural decode straight from the RV32I tables.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic we, input logic [4:0] wrd,
                                        input logic [31:0] wd);
        logic [3:0]  base_tab [8];
        logic [31:0] r1, r2, ii, is, iu;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        writes;
        exp_t        e;
        base_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r1 = operand(ins[19:15], we, wrd, wd);
        r2 = operand(ins[24:20], we, wrd, wd);
        ii = $signed(ins) >>> 20;
        is = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;
        iu = ins & 32'hFFFF_F000;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.rd = ins[11:7];
        e.f3 = f3;
        e.pc = pc;
        e.sd = r2;
        writes = 1'b1;
        case (op)
            7'b0110011: begin
                e.x = r1; e.y = r2;
                if (f7 == 7'h00) e.alu = base_tab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                else e.unsup = 1'b1;
            end
            7'b0010011: begin
                e.x = r1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.y = {27'd0, ins[24:20]};
                    if (f7 == 7'h00) e.alu = base_tab[f3];
                    else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                    else e.unsup = 1'b1;
                end else begin
                    e.y = ii; e.alu = base_tab[f3];
                end
            end
            7'b0110111: e.y = iu;
            7'b0010111: begin e.x = pc; e.y = iu; end
            7'b1101111, 7'b1100111: begin e.x = pc; e.y = 32'd4; end
            7'b0000011: begin e.x = r1; e.y = ii; e.mem_rd = 1'b1; end
            7'b0100011: begin e.x = r1; e.y = is; e.mem_wr = 1'b1; writes = 1'b0; end
            default: e.unsup = 1'b1;
        endcase
        if (e.unsup) begin
            e.alu = 4'd0; e.mem_rd = 1'b0; e.mem_wr = 1'b0; writes = 1'b0;
        end
        e.rd_we = writes && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic er, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd, input logic r);
        logic acc;
        exp_t nxt;
        @(negedge clk);
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; ex_ready = er; flush = fl;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        check("in_ready", in_ready, !m_valid || er);
        acc = v && (!m_valid || er);
        nxt = ref_decode(ins, pc, we, wrd, wd);
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m = '0; m.pc = RST_PC; m_stall = 0;
        end else begin
            if (m_valid && !er) m_stall = m_stall + 1;
            if (fl) m_valid = 1'b0;
            else if (acc) begin m_valid = 1'b1; m = nxt; end
            else if (!m_valid || er) m_valid = 1'b0;
        end
        #1;
        check("ex_valid", ex_valid, m_valid);
        check("stall_cnt", stall_cnt, m_stall);
        if (m_valid) begin
            check("alu_ctrl", alu_ctrl, m.alu);
            check("ex_rd", ex_rd, m.rd);
            check("ex_rd_we", ex_rd_we, m.rd_we);
            check("ex_mem_rd", ex_mem_rd, m.mem_rd);
            check("ex_mem_wr", ex_mem_wr, m.mem_wr);
            check("ex_funct3", ex_funct3, m.f3);
            check("ex_pc", ex_pc, m.pc);
            check("ex_unsup", ex_unsup, m.unsup);
            if (!m.unsup) begin
                check("data_x", data_x, m.x);
                check("data_y", data_y, m.y);
            end
            if (m.mem_wr) check("store_data", ex_store_data, m.sd);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [10];
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};
        ins = $urandom;
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 11);
        if (k < 10) ins[6:0] = ops[k];
        if (k == 10) ins[6:0] = 7'b0001111;
        if (k <= 1) begin
            case ($urandom_range(0, 3))
                0, 1:    ins[31:25] = 7'h00;
                2:       ins[31:25] = 7'h20;
                default: ins[31:25] = 7'($urandom);
            endcase
        end
        return ins;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF0_0293; in_pc = 32'h40;
        ex_ready = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        m_valid = 1'b0; m = '0; m.pc = RST_PC; m_stall = '0;
        @(posedge clk);
        step(1'b1, 32'hFFF0_0293, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_alu_ctrl", alu_ctrl, 4'd0);
        check("rst_data_x", data_x, 32'd0);
        check("rst_data_y", data_y, 32'd0);
        check("rst_ex_pc", ex_pc, RST_PC);
        check("rst_ex_rd_we", ex_rd_we, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // ADDI x5,x0,-1
        step(1'b1, 32'hFFF0_0293, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("addi_alu", alu_ctrl, 4'd0);
        check("addi_x", data_x, 32'd0);
        check("addi_y", data_y, 32'hFFFF_FFFF);
        check("addi_rd", ex_rd, 5'd5);
        check("addi_rd_we", ex_rd_we, 1'b1);

        // Four stalled cycles, then SRAI x1,x2,3 loads once EX drains.
        rf[2] = 32'h8000_0000;
        for (int i = 0; i < 4; i++)
            step(1'b1, rand_instr(), 32'h44 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_cnt4", stall_cnt, 32'd4);
        check("stall_hold_y", data_y, 32'hFFFF_FFFF);
        step(1'b1, 32'h4031_5093, 32'h60, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("srai_alu", alu_ctrl, 4'd7);
        check("srai_x", data_x, 32'h8000_0000);
        check("srai_y", data_y, 32'd3);

        // SUB x3,x1,x2 with bypass of x1, then SUB x3,x0,x2 with wb_rd=0.
        rf[1] = 32'd7;
        step(1'b1, 32'h4020_81B3, 32'h64, 1'b1, 1'b0, 1'b1, 5'd1, 32'd9, 1'b0);
        check("sub_bypass_x", data_x, 32'd9);
        check("sub_alu", alu_ctrl, 4'd1);
        step(1'b1, 32'h4020_01B3, 32'h68, 1'b1, 1'b0, 1'b1, 5'd0, 32'd9, 1'b0);
        check("sub_x0", data_x, 32'd0);

        // Flush with a simultaneous accept: nothing survives.
        step(1'b1, 32'h1234_52B7, 32'h6C, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("flush_valid", ex_valid, 1'b0);
        step(1'b0, 32'h1234_52B7, 32'h6C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("flush_stays", ex_valid, 1'b0);

        // Unsupported: BEQ, ECALL, compressed-looking encoding.
        step(1'b1, 32'h0000_0063, 32'h70, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("beq_unsup", ex_unsup, 1'b1);
        step(1'b1, 32'h0000_0073, 32'h74, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("ecall_unsup", ex_unsup, 1'b1);
        step(1'b1, 32'h0000_0290, 32'h78, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("c00_unsup", ex_unsup, 1'b1);
        check("c00_rd_we", ex_rd_we, 1'b0);

        // SW x6,8(x7)
        rf[6] = 32'h1234_5678;
        rf[7] = 32'h0000_0100;
        step(1'b1, 32'h0063_A423, 32'h7C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("sw_mem_wr", ex_mem_wr, 1'b1);
        check("sw_y", data_y, 32'd8);
        check("sw_x", data_x, 32'h100);
        check("sw_sd", ex_store_data, 32'h1234_5678);
        check("sw_rd_we", ex_rd_we, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rf[$urandom_range(1, 31)] = $urandom;
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
